// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU-op one-hot type used by the ID stage.
package riscv_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic add;
        logic sub;
        logic xor_;
        logic or_;
        logic and_;
    } alu_ops_t;

    localparam alu_ops_t OPS_NONE = 5'b00000;
    localparam alu_ops_t OPS_ADD  = 5'b10000;
    localparam alu_ops_t OPS_SUB  = 5'b01000;
    localparam alu_ops_t OPS_XOR  = 5'b00100;
    localparam alu_ops_t OPS_OR   = 5'b00010;
    localparam alu_ops_t OPS_AND  = 5'b00001;

    // Field values of the canonical NOP, addi x0,x0,0.
    localparam logic [4:0] NOP_RD          = 5'd0;
    localparam logic       NOP_WB_EN       = 1'b1;
    localparam logic       NOP_ALU_RS2_REG = 1'b0;
    localparam alu_ops_t   NOP_OPS         = OPS_ADD;

endpackage

// File: rtl/id_stage_regfile.sv
// 2R1W register file: combinational reads with write-through, synchronous write, x0 reads as zero.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    // NOTE: the architectural state must come up zeroed, so this array is reset
    // explicitly (it maps to flops, not a RAM macro); state updates use <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0)                  ? '0      :
                      (we_i && waddr_i == raddr1_i)     ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                  ? '0      :
                      (we_i && waddr_i == raddr2_i)     ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage feeding the ID/EX register; combinational decode plus ALU-loopback tracker.
// Define ID_ILLEGAL_CNT_EN to add the saturating illegal_count output.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic            writeback_en,
    output logic            alu_rs2_reg,
    output logic [XLEN-1:0] imm,
    output logic            add_en,
    output logic            sub_en,
    output logic            xor_en,
    output logic            or_en,
    output logic            and_en,
`ifdef ID_ILLEGAL_CNT_EN
    output logic [31:0]     illegal_count,
`endif
    output logic            rs1_alu_loopback,
    output logic            rs2_alu_loopback
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opcode = instr_in[6:0];
    assign rd_f   = instr_in[11:7];
    assign funct3 = instr_in[14:12];
    assign rs1_f  = instr_in[19:15];
    assign rs2_f  = instr_in[24:20];
    assign funct7 = instr_in[31:25];

    logic [XLEN-1:0] rf_rdata1, rf_rdata2;

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_f),
        .raddr2_i (rs2_f),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    logic     supported, is_r, dec_valid;
    alu_ops_t ops;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        supported = 1'b0;
        is_r      = 1'b0;
        ops       = OPS_NONE;
        case (opcode)
            OP_R: begin
                is_r = 1'b1;
                if (funct7 == F7_BASE) begin
                    supported = 1'b1;
                    case (funct3)
                        F3_ADD:  ops = OPS_ADD;
                        F3_XOR:  ops = OPS_XOR;
                        F3_OR:   ops = OPS_OR;
                        F3_AND:  ops = OPS_AND;
                        default: supported = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    supported = 1'b1;
                    ops       = OPS_SUB;
                end
            end
            OP_I: begin
                supported = 1'b1;
                case (funct3)
                    F3_ADD:  ops = OPS_ADD;
                    F3_XOR:  ops = OPS_XOR;
                    F3_OR:   ops = OPS_OR;
                    F3_AND:  ops = OPS_AND;
                    default: supported = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    assign dec_valid = instr_valid && !rst && supported;

    logic [4:0] prev_rd_q, prev_rd_d;
    logic       prev_wb_q, prev_wb_d;

    always_comb begin
        rd_addr          = NOP_RD;
        rs1              = '0;
        rs2              = '0;
        imm              = '0;
        writeback_en     = NOP_WB_EN;
        alu_rs2_reg      = NOP_ALU_RS2_REG;
        {add_en, sub_en, xor_en, or_en, and_en} = NOP_OPS;
        rs1_alu_loopback = 1'b0;
        rs2_alu_loopback = 1'b0;
        if (dec_valid) begin
            rd_addr          = rd_f;
            rs1              = rf_rdata1;
            rs2              = is_r ? rf_rdata2 : '0;
            imm              = is_r ? '0 : {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
            writeback_en     = 1'b1;
            alu_rs2_reg      = is_r;
            {add_en, sub_en, xor_en, or_en, and_en} = ops;
            rs1_alu_loopback = prev_wb_q && prev_rd_q == rs1_f && rs1_f != '0;
            rs2_alu_loopback = is_r && prev_wb_q && prev_rd_q == rs2_f && rs2_f != '0;
        end
    end

    // Only a real decoded writer to a nonzero rd can be forwarded from the ALU next cycle.
    assign prev_wb_d = dec_valid && writeback_en && rd_addr != '0;
    assign prev_rd_d = rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_wb_q <= 1'b0;
            prev_rd_q <= '0;
        end else begin
            prev_wb_q <= prev_wb_d;
            prev_rd_q <= prev_rd_d;
        end
    end

`ifdef ID_ILLEGAL_CNT_EN
    logic [31:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (instr_valid && !supported && illegal_cnt_q != '1) begin
            illegal_cnt_q <= illegal_cnt_q + 32'd1;
        end
    end

    assign illegal_count = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage; covers reset NOP, decode, write-through, loopback.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr;
    logic [31:0] rs1, rs2, imm;
    logic        writeback_en, alu_rs2_reg;
    logic        add_en, sub_en, xor_en, or_en, and_en;
    logic        rs1_alu_loopback, rs2_alu_loopback;
`ifdef ID_ILLEGAL_CNT_EN
    logic [31:0] illegal_count;
`endif

    always #5 clk = ~clk;

    id_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .wb_en            (wb_en),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .rd_addr          (rd_addr),
        .rs1              (rs1),
        .rs2              (rs2),
        .writeback_en     (writeback_en),
        .alu_rs2_reg      (alu_rs2_reg),
        .imm              (imm),
        .add_en           (add_en),
        .sub_en           (sub_en),
        .xor_en           (xor_en),
        .or_en            (or_en),
        .and_en           (and_en),
`ifdef ID_ILLEGAL_CNT_EN
        .illegal_count    (illegal_count),
`endif
        .rs1_alu_loopback (rs1_alu_loopback),
        .rs2_alu_loopback (rs2_alu_loopback)
    );

    // Op one-hots in the order {add, sub, xor, or, and}.
    localparam logic [4:0] E_ADD = 5'b10000;
    localparam logic [4:0] E_SUB = 5'b01000;
    localparam logic [4:0] E_XOR = 5'b00100;
    localparam logic [4:0] E_OR  = 5'b00010;
    localparam logic [4:0] E_AND = 5'b00001;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [4:0]  e_rd;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic        e_rs2reg;
        logic [4:0]  e_ops;
        logic        e_lb1;
        logic        e_lb2;
        logic [31:0] e_ill;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_rd, input logic [31:0] e_rs1,
                             input logic [31:0] e_rs2, input logic [31:0] e_imm, input logic e_rs2reg,
                             input logic [4:0] e_ops, input logic e_lb1, input logic e_lb2);
        check({tag, ".rd_addr"},      32'(rd_addr), 32'(e_rd));
        check({tag, ".rs1"},          rs1, e_rs1);
        check({tag, ".rs2"},          rs2, e_rs2);
        check({tag, ".imm"},          imm, e_imm);
        check({tag, ".writeback_en"}, 32'(writeback_en), 32'd1);
        check({tag, ".alu_rs2_reg"},  32'(alu_rs2_reg), 32'(e_rs2reg));
        check({tag, ".ops"},          32'({add_en, sub_en, xor_en, or_en, and_en}), 32'(e_ops));
        check({tag, ".rs1_lb"},       32'(rs1_alu_loopback), 32'(e_lb1));
        check({tag, ".rs2_lb"},       32'(rs2_alu_loopback), 32'(e_lb2));
    endtask

    task automatic check_nop(input string tag);
        check_out(tag, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, E_ADD, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic wbe,
                                input logic [4:0] wba, input logic [31:0] wbd, input logic [4:0] rd,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                                input logic rs2reg, input logic [4:0] ops, input logic lb1,
                                input logic lb2, input logic [31:0] ill);
        vec_t v;
        v.instr = instr; v.valid = valid; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.e_rd = rd; v.e_rs1 = r1; v.e_rs2 = r2; v.e_imm = im; v.e_rs2reg = rs2reg;
        v.e_ops = ops; v.e_lb1 = lb1; v.e_lb2 = lb2; v.e_ill = ill;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [31:0] instr, input logic valid,
                         input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        @(negedge clk);
        rst = r; instr_in = instr; instr_valid = valid;
        wb_en = wbe; wb_addr = wba; wb_data = wbd;
        #2;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(32'h0000_0000, 0, 1, 5'd1, 32'd5,        0, 0, 0, 0, 0, E_ADD, 0, 0, 0);
        vecs[1]  = mk(32'h0000_0000, 0, 1, 5'd2, 32'd7,        0, 0, 0, 0, 0, E_ADD, 0, 0, 0);
        vecs[2]  = mk(32'h0020_81B3, 1, 0, 5'd0, 32'd0,        3, 5, 7, 0, 1, E_ADD, 0, 0, 0);
        vecs[3]  = mk(32'hFFF0_0213, 1, 0, 5'd0, 32'd0,        4, 0, 0, 32'hFFFF_FFFF, 0, E_ADD, 0, 0, 0);
        vecs[4]  = mk(32'h0010_0293, 1, 0, 5'd0, 32'd0,        5, 0, 0, 1, 0, E_ADD, 0, 0, 0);
        vecs[5]  = mk(32'h4052_8333, 1, 0, 5'd0, 32'd0,        6, 0, 0, 0, 1, E_SUB, 1, 1, 0);
        vecs[6]  = mk(32'h0010_0293, 1, 0, 5'd0, 32'd0,        5, 0, 0, 1, 0, E_ADD, 0, 0, 0);
        vecs[7]  = mk(32'h4052_8333, 0, 0, 5'd0, 32'd0,        0, 0, 0, 0, 0, E_ADD, 0, 0, 0);
        vecs[8]  = mk(32'h4052_8333, 1, 1, 5'd5, 32'd1,        6, 1, 1, 0, 1, E_SUB, 0, 0, 0);
        vecs[9]  = mk(32'h0003_C433, 1, 1, 5'd7, 32'hA5A5_A5A5, 8, 32'hA5A5_A5A5, 0, 0, 1, E_XOR, 0, 0, 0);
        vecs[10] = mk(32'h0000_0000, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, E_ADD, 0, 0, 0);
        vecs[11] = mk(32'h0000_64B3, 1, 0, 5'd0, 32'd0,        9, 0, 0, 0, 1, E_OR, 0, 0, 0);
        vecs[12] = mk(32'h0013_F533, 1, 0, 5'd0, 32'd0,        10, 32'hA5A5_A5A5, 5, 0, 1, E_AND, 0, 0, 0);
        vecs[13] = mk(32'h80A5_7593, 1, 0, 5'd0, 32'd0,        11, 0, 0, 32'hFFFF_F80A, 0, E_AND, 1, 0, 0);
        vecs[14] = mk(32'h0F00_E613, 1, 0, 5'd0, 32'd0,        12, 5, 0, 32'h0000_00F0, 0, E_OR, 0, 0, 0);
        vecs[15] = mk(32'h0000_0073, 1, 0, 5'd0, 32'd0,        0, 0, 0, 0, 0, E_ADD, 0, 0, 0);
        vecs[16] = mk(32'h4003_C433, 1, 0, 5'd0, 32'd0,        0, 0, 0, 0, 0, E_ADD, 0, 0, 1);
        vecs[17] = mk(32'h0000_0073, 0, 0, 5'd0, 32'd0,        0, 0, 0, 0, 0, E_ADD, 0, 0, 2);
        vecs[18] = mk(32'h0020_81B3, 1, 0, 5'd0, 32'd0,        3, 5, 7, 0, 1, E_ADD, 0, 0, 2);

        // Reset held two cycles with a valid instruction present: outputs must still be the NOP.
        rst = 1'b1; instr_in = 32'h0020_81B3; instr_valid = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check_nop("reset");
`ifdef ID_ILLEGAL_CNT_EN
        check("reset.illegal_count", illegal_count, 32'd0);
`endif

        for (int i = 0; i < 19; i++) begin
            drive(1'b0, vecs[i].instr, vecs[i].valid, vecs[i].wbe, vecs[i].wba, vecs[i].wbd);
            check_out($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_rs1, vecs[i].e_rs2,
                      vecs[i].e_imm, vecs[i].e_rs2reg, vecs[i].e_ops, vecs[i].e_lb1, vecs[i].e_lb2);
`ifdef ID_ILLEGAL_CNT_EN
            check($sformatf("vec%0d.illegal_count", i), illegal_count, vecs[i].e_ill);
`endif
        end

        // Mid-stream reset: tracker and register file both clear on the reset edge.
        drive(1'b0, 32'h0010_0293, 1'b1, 1'b1, 5'd5, 32'd9);
        check_out("mid.producer", 5'd5, 32'd0, 32'd0, 32'd1, 1'b0, E_ADD, 1'b0, 1'b0);
        drive(1'b1, 32'h4052_8333, 1'b1, 1'b0, 5'd0, 32'd0);
        check_nop("mid.in_reset");
        drive(1'b0, 32'h4052_8333, 1'b1, 1'b0, 5'd0, 32'd0);
        check_out("mid.after_reset", 5'd6, 32'd0, 32'd0, 32'd0, 1'b1, E_SUB, 1'b0, 1'b0);
        drive(1'b0, 32'h0020_81B3, 1'b1, 1'b0, 5'd0, 32'd0);
        check_out("mid.rf_cleared", 5'd3, 32'd0, 32'd0, 32'd0, 1'b1, E_ADD, 1'b0, 1'b0);
`ifdef ID_ILLEGAL_CNT_EN
        check("mid.illegal_count", illegal_count, 32'd0);
        drive(1'b0, 32'h0000_0073, 1'b1, 1'b0, 5'd0, 32'd0);
        check("ill.before", illegal_count, 32'd0);
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'd0);
        check("ill.after", illegal_count, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
